// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Round-robin sharing of one memory port between IFU and LSU,
//           one transaction in flight (arbitrate, request, response, deliver).
// Rev     : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int   MW      = DW / 8;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DLV  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   wmask_q, wmask_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic            mem_rsp_ready_q, mem_rsp_ready_d;
    logic            ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic            lsu_rsp_valid_q, lsu_rsp_valid_d;

    logic            grant_ifu;
    logic            grant_lsu;
    logic            owner_rsp_ready;

    // Grants are combinational; qualifying with rst keeps both ready outputs low while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst && (state_q == S_IDLE)) begin
            grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
            grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));
        end
    end

    assign owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        rdata_d         = rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_rsp_ready_d = mem_rsp_ready_q;
        ifu_rsp_valid_d = ifu_rsp_valid_q;
        lsu_rsp_valid_d = lsu_rsp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    state_d         = S_REQ;
                    owner_d         = grant_lsu ? OWN_LSU : OWN_IFU;
                    last_grant_d    = grant_lsu ? OWN_LSU : OWN_IFU;
                    mem_req_valid_d = 1'b1;
                    if (grant_lsu) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d         = S_RSP;
                    mem_req_valid_d = 1'b0;
                    mem_rsp_ready_d = 1'b1;
                end
            end
            S_RSP: begin
                if (mem_rsp_valid) begin
                    state_d         = S_DLV;
                    mem_rsp_ready_d = 1'b0;
                    rdata_d         = mem_rdata;
                    ifu_rsp_valid_d = (owner_q == OWN_IFU);
                    lsu_rsp_valid_d = (owner_q == OWN_LSU);
                end
            end
            S_DLV: begin
                if (owner_rsp_ready) begin
                    state_d         = S_IDLE;
                    ifu_rsp_valid_d = 1'b0;
                    lsu_rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_LSU;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            rdata_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_rsp_ready_q <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            rdata_q         <= rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_rsp_ready_q <= mem_rsp_ready_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign mem_rsp_ready = mem_rsp_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter: vector table, directed corner
//           sequences and random traffic against a transaction-level model.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    typedef struct packed {
        logic        ifu_v;
        logic [31:0] ifu_addr;
        logic        ifu_rr;
        logic        lsu_v;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wmask;
        logic        lsu_rr;
        logic        mreq_rdy;
        logic        mrsp_v;
        logic [31:0] mrdata;
    } in_t;

    typedef struct packed {
        logic        ifu_req_ready;
        logic        ifu_rsp_valid;
        logic        lsu_req_ready;
        logic        lsu_rsp_valid;
        logic        mem_req_valid;
        logic        mem_rsp_ready;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wmask;
        logic [31:0] rsp_rdata;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    logic rst;
    in_t  din;
    out_t dout;

    logic        ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid;
    logic        mem_req_valid, mem_rsp_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata, rsp_rdata;
    logic [3:0]  mem_wmask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (din.ifu_v),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (din.ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (din.ifu_rr),
        .lsu_req_valid (din.lsu_v),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (din.lsu_addr),
        .lsu_wen       (din.lsu_wen),
        .lsu_wdata     (din.lsu_wdata),
        .lsu_wmask     (din.lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (din.lsu_rr),
        .rsp_rdata     (rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (din.mreq_rdy),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (din.mrsp_v),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rdata     (din.mrdata)
    );

    assign dout = {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
                   mem_req_valid, mem_rsp_ready, mem_wen, mem_addr, mem_wdata,
                   mem_wmask, rsp_rdata};

    int checks   = 0;
    int failures = 0;

    // Reference model: the single in-flight transaction and the round-robin pointer.
    bit          m_busy, m_issued, m_answered, m_owner_lsu, m_last_lsu;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_wen;
    logic [3:0]  m_wmask;

    int agq[$];   // grants observed on the DUT: 0 = IFU, 1 = LSU
    vec_t tbl[$];

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_answered = 0; m_owner_lsu = 0; m_last_lsu = 1;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_wen = 1'b0; m_wmask = '0;
    endtask

    function automatic out_t model_out(input in_t i);
        out_t o;
        bit   idle;
        o    = '0;
        idle = (rst === 1'b1) && !m_busy;
        o.ifu_req_ready = idle && i.ifu_v && (!i.lsu_v || m_last_lsu);
        o.lsu_req_ready = idle && i.lsu_v && (!i.ifu_v || !m_last_lsu);
        o.mem_req_valid = m_busy && !m_issued;
        o.mem_rsp_ready = m_busy && m_issued && !m_answered;
        o.ifu_rsp_valid = m_busy && m_answered && !m_owner_lsu;
        o.lsu_rsp_valid = m_busy && m_answered && m_owner_lsu;
        o.mem_wen   = m_wen;
        o.mem_addr  = m_addr;
        o.mem_wdata = m_wdata;
        o.mem_wmask = m_wmask;
        o.rsp_rdata = m_rdata;
        return o;
    endfunction

    task automatic model_update(input in_t i);
        out_t o;
        o = model_out(i);
        if (o.ifu_req_ready || o.lsu_req_ready) begin
            m_busy = 1; m_issued = 0; m_answered = 0;
            m_owner_lsu = o.lsu_req_ready;
            m_last_lsu  = o.lsu_req_ready;
            if (o.lsu_req_ready) begin
                m_addr = i.lsu_addr; m_wen = i.lsu_wen; m_wdata = i.lsu_wdata; m_wmask = i.lsu_wmask;
            end else begin
                m_addr = i.ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
            end
        end else if (m_busy && !m_issued) begin
            if (i.mreq_rdy) m_issued = 1;
        end else if (m_busy && !m_answered) begin
            if (i.mrsp_v) begin
                m_answered = 1;
                m_rdata    = i.mrdata;
            end
        end else if (m_busy) begin
            if (m_owner_lsu ? i.lsu_rr : i.ifu_rr) m_busy = 0;
        end
    endtask

    task automatic check_out(input string name, input out_t exp);
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, dout, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, exp);
        end
    endtask

    // Called at a negedge: drive, compare, advance the model across the coming posedge.
    task automatic step(input string name, input in_t i, input bit use_tbl, input out_t e);
        out_t exp;
        din = i;
        #1;
        exp = use_tbl ? e : model_out(i);
        check_out(name, exp);
        if (dout.ifu_req_ready === 1'b1) agq.push_back(0);
        if (dout.lsu_req_ready === 1'b1) agq.push_back(1);
        model_update(i);
        @(negedge clk);
    endtask

    task automatic do_reset();
        din = '0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    in_t  i;
    out_t o;
    logic [3:0] got;
    int stall_ok;

    initial begin
        rst = 1'b0;
        din = '0;
        model_reset();
        #1;
        check_out("reset_state", '0);
        do_reset();

        // IFU-only read, then LSU write with a stalled request channel
        i = '0; o = '0;
        i.ifu_v = 1; i.ifu_addr = 32'h8000_0000; o.ifu_req_ready = 1;                push(i, o);
        i.ifu_v = 0; i.mreq_rdy = 1; o.ifu_req_ready = 0;
        o.mem_req_valid = 1; o.mem_addr = 32'h8000_0000;                             push(i, o);
        i.mreq_rdy = 0; i.mrsp_v = 1; i.mrdata = 32'h0000_0413;
        o.mem_req_valid = 0; o.mem_rsp_ready = 1;                                    push(i, o);
        i.mrsp_v = 0; i.mrdata = '0; o.mem_rsp_ready = 0;
        o.ifu_rsp_valid = 1; o.rsp_rdata = 32'h0000_0413;                            push(i, o);
        i.ifu_rr = 1;                                                                push(i, o);
        i.ifu_rr = 0; o.ifu_rsp_valid = 0;                                           push(i, o);
        i.lsu_v = 1; i.lsu_addr = 32'h8000_1000; i.lsu_wen = 1;
        i.lsu_wdata = 32'hDEAD_BEEF; i.lsu_wmask = 4'hF; o.lsu_req_ready = 1;        push(i, o);
        i.lsu_v = 0; i.lsu_addr = '0; i.lsu_wdata = '0; i.lsu_wen = 0; i.lsu_wmask = '0;
        o.lsu_req_ready = 0; o.mem_req_valid = 1; o.mem_addr = 32'h8000_1000;
        o.mem_wen = 1; o.mem_wdata = 32'hDEAD_BEEF; o.mem_wmask = 4'hF;              push(i, o);
        i.mrsp_v = 1; i.mrdata = 32'h1234_5678;                                      push(i, o);
        i.mrsp_v = 0; i.mrdata = '0;                                                 push(i, o);
        i.mreq_rdy = 1;                                                              push(i, o);
        i.mreq_rdy = 0; o.mem_req_valid = 0; o.mem_rsp_ready = 1;                    push(i, o);
        i.mrsp_v = 1; i.mrdata = 32'h0000_0001;                                      push(i, o);
        i.mrsp_v = 0; i.mrdata = '0; i.lsu_rr = 1; o.mem_rsp_ready = 0;
        o.lsu_rsp_valid = 1; o.rsp_rdata = 32'h0000_0001;                            push(i, o);
        i.lsu_rr = 0; i.mrsp_v = 1; i.mrdata = 32'hFFFF_FFFF; o.lsu_rsp_valid = 0;   push(i, o);
        i.mrsp_v = 0; i.mrdata = '0;                                                 push(i, o);

        for (int k = 0; k < tbl.size(); k++) step($sformatf("vec%0d", k), tbl[k].i, 1, tbl[k].o);

        // Continuous contention from reset: grants alternate starting with IFU
        do_reset();
        agq.delete();
        for (int k = 0; k < 40; k++) begin
            i = '0;
            i.ifu_v = 1; i.ifu_addr = 32'h8000_0100 + k * 4;
            i.lsu_v = 1; i.lsu_addr = 32'h9000_0000 + k * 4; i.lsu_wen = k[0];
            i.lsu_wdata = $urandom; i.lsu_wmask = 4'h3;
            i.mreq_rdy = 1; i.mrsp_v = 1; i.mrdata = $urandom;
            i.ifu_rr = 1; i.lsu_rr = 1;
            step("contend", i, 0, '0);
        end
        check_val("grant_count_ge4", {31'd0, agq.size() >= 4}, 32'd1);
        got = 4'hF;
        for (int k = 0; k < 4 && k < agq.size(); k++) got[k] = agq[k][0];
        check_val("grant_order", {28'd0, got}, {28'd0, 4'b1010});

        // IFU response held 4 cycles in delivery while LSU waits
        while (m_busy) begin
            i = '0; i.ifu_rr = 1; i.lsu_rr = 1; i.mreq_rdy = 1; i.mrsp_v = 1;
            step("drain", i, 0, '0);
        end
        i = '0; i.ifu_v = 1; i.ifu_addr = 32'h8000_0200;   step("dlv_grant", i, 0, '0);
        i = '0; i.lsu_v = 1; i.lsu_addr = 32'h8000_0300; i.mreq_rdy = 1;
        step("dlv_req", i, 0, '0);
        i.mreq_rdy = 0; i.mrsp_v = 1; i.mrdata = 32'hCAFE_F00D;
        step("dlv_rsp", i, 0, '0);
        i.mrsp_v = 0; i.mrdata = '0;
        stall_ok = 0;
        for (int k = 0; k < 4; k++) begin
            din = i;
            #1;
            if (ifu_rsp_valid === 1'b1 && lsu_req_ready === 1'b0 && rsp_rdata === 32'hCAFE_F00D)
                stall_ok++;
            #1;
            step("dlv_stall", i, 0, '0);
        end
        check_val("dlv_stall_cycles", stall_ok, 32'd4);
        i.ifu_rr = 1;                   step("dlv_release", i, 0, '0);
        i.ifu_rr = 0;                   step("dlv_lsu_grant", i, 0, '0);

        // Asynchronous reset while waiting for the memory response
        do_reset();
        i = '0; i.ifu_v = 1; i.lsu_v = 1; i.ifu_addr = 32'h8000_0400;
        i.lsu_addr = 32'h8000_0500; i.mreq_rdy = 1;
        step("mid_grant", i, 0, '0);
        step("mid_req", i, 0, '0);
        #2 rst = 1'b0;
        #1 check_out("async_reset_outputs", '0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        din = i;
        #1 check_val("post_reset_ifu_grant", {31'd0, ifu_req_ready}, 32'd1);
        #1;
        step("post_reset", i, 0, '0);

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            i.ifu_v     = ($urandom_range(0, 3) != 0);
            i.ifu_addr  = $urandom;
            i.ifu_rr    = ($urandom_range(0, 2) != 0);
            i.lsu_v     = ($urandom_range(0, 2) != 0);
            i.lsu_addr  = $urandom;
            i.lsu_wen   = $urandom_range(0, 1);
            i.lsu_wdata = $urandom;
            i.lsu_wmask = $urandom_range(0, 15);
            i.lsu_rr    = ($urandom_range(0, 2) != 0);
            i.mreq_rdy  = $urandom_range(0, 1);
            i.mrsp_v    = $urandom_range(0, 1);
            i.mrdata    = $urandom;
            step("random", i, 0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
